// File: rtl/gelato_register_bank_scheduler.sv
// Per-cycle arbiter sharing single-ported register banks between operand-collector
// reads and the writeback port; read data is steered back to the winner one cycle later.
module gelato_register_bank_scheduler #(
   parameter int BANK_NUM      = 4,
   parameter int REQ_NUM       = 4,
   parameter int WARP_W        = 5,
   parameter int REG_W         = 5,
   parameter int DATA_W        = 1024,
   parameter int WB_STARVE_MAX = 3
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    rdy,
   input  logic [REQ_NUM-1:0]                      req_valid,
   input  logic [REQ_NUM-1:0][WARP_W-1:0]          req_warp,
   input  logic [REQ_NUM-1:0][REG_W-1:0]           req_reg,
   output logic [REQ_NUM-1:0]                      req_ready,
   input  logic                                    wb_valid,
   input  logic [WARP_W-1:0]                       wb_warp,
   input  logic [REG_W-1:0]                        wb_reg,
   output logic                                    wb_ready,
   output logic [BANK_NUM-1:0]                     bank_rd_en,
   output logic [BANK_NUM-1:0]                     bank_write,
   output logic [BANK_NUM-1:0][REG_W-$clog2(BANK_NUM)-1:0] bank_reg_num,
   output logic [BANK_NUM-1:0][WARP_W-1:0]         bank_warp_num,
   input  logic [BANK_NUM-1:0][DATA_W-1:0]         bank_rdata,
   output logic [REQ_NUM-1:0]                      resp_valid,
   output logic [REQ_NUM-1:0][DATA_W-1:0]          resp_data
);

   localparam int BANK_W = $clog2(BANK_NUM);
   localparam int ROW_W  = REG_W - BANK_W;
   localparam int RR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int ST_W   = $clog2(WB_STARVE_MAX + 1);

   logic                               active;
   logic [BANK_W-1:0]                  wb_bank;
   logic [BANK_NUM-1:0][RR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [BANK_NUM-1:0][ST_W-1:0]      starve_q, starve_d;
   logic [BANK_NUM-1:0]                rd_grant, wr_grant;
   logic [BANK_NUM-1:0][RR_W-1:0]      win_idx;
   logic [REQ_NUM-1:0]                 resp_valid_q, resp_valid_d;
   logic [REQ_NUM-1:0][BANK_W-1:0]     resp_bank_q, resp_bank_d;

   // Reset also forces every combinational command low while it is held.
   assign active  = rdy & ~rst;
   assign wb_bank = wb_reg[BANK_W-1:0];

   // Returns {found, index} of the first candidate at or after ptr, wrapping.
   function automatic logic [RR_W:0] rr_pick(input logic [REQ_NUM-1:0] cand,
                                             input logic [RR_W-1:0]    ptr);
      logic            found;
      logic [RR_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         int j;
         j = (int'(ptr) + k) % REQ_NUM;
         if (!found && cand[j]) begin
            found = 1'b1;
            idx   = RR_W'(j);
         end
      end
      return {found, idx};
   endfunction

   genvar gi, gj;
   generate
      for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
         logic [REQ_NUM-1:0] cand;
         logic [RR_W:0]      pick;
         logic               has_cand;
         logic               wb_here;
         logic               wb_win;

         for (gj = 0; gj < REQ_NUM; gj++) begin : g_cand
            assign cand[gj] = req_valid[gj] && (req_reg[gj][BANK_W-1:0] == BANK_W'(gi));
         end

         assign pick     = rr_pick(cand, rr_ptr_q[gi]);
         assign has_cand = |cand;
         assign wb_here  = wb_valid && (wb_bank == BANK_W'(gi));
         // Writeback keeps the bank until it has beaten waiting reads WB_STARVE_MAX times in a row.
         assign wb_win   = wb_here && (!has_cand || (starve_q[gi] < ST_W'(WB_STARVE_MAX)));

         assign wr_grant[gi] = active && wb_win;
         assign rd_grant[gi] = active && has_cand && !wb_win;
         assign win_idx[gi]  = pick[RR_W-1:0];

         assign starve_d[gi] = !active ? starve_q[gi] :
                               (wb_here && has_cand && (starve_q[gi] < ST_W'(WB_STARVE_MAX))) ?
                               starve_q[gi] + 1'b1 : '0;
         assign rr_ptr_d[gi] = rd_grant[gi] ? RR_W'((int'(win_idx[gi]) + 1) % REQ_NUM)
                                            : rr_ptr_q[gi];

         assign bank_write[gi]    = wr_grant[gi];
         assign bank_rd_en[gi]    = rd_grant[gi];
         assign bank_reg_num[gi]  = wr_grant[gi] ? wb_reg[REG_W-1:BANK_W] :
                                    rd_grant[gi] ? req_reg[win_idx[gi]][REG_W-1:BANK_W] :
                                    {ROW_W{1'b0}};
         assign bank_warp_num[gi] = wr_grant[gi] ? wb_warp :
                                    rd_grant[gi] ? req_warp[win_idx[gi]] : '0;
      end

      for (gi = 0; gi < REQ_NUM; gi++) begin : g_req
         logic [BANK_W-1:0] tgt;
         assign tgt = req_reg[gi][BANK_W-1:0];

         assign req_ready[gi]    = rd_grant[tgt] && (win_idx[tgt] == RR_W'(gi));
         assign resp_valid_d[gi] = req_ready[gi];
         assign resp_bank_d[gi]  = req_ready[gi] ? tgt : resp_bank_q[gi];
         assign resp_data[gi]    = resp_valid_q[gi] ? bank_rdata[resp_bank_q[gi]] : '0;
      end
   endgenerate

   assign wb_ready   = |wr_grant;
   assign resp_valid = resp_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         starve_q     <= '0;
         resp_valid_q <= '0;
         resp_bank_q  <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         starve_q     <= starve_d;
         resp_valid_q <= resp_valid_d;
         resp_bank_q  <= resp_bank_d;
      end
   end

endmodule

// File: tb/tb_gelato_register_bank_scheduler.sv
// Directed bench for gelato_register_bank_scheduler: a per-cycle rule model checked on
// every falling edge, plus hand-computed expectations for each scenario.
module tb_gelato_register_bank_scheduler;

   localparam int BN = 4;
   localparam int RN = 4;
   localparam int DW = 1024;
   localparam int SMAX = 3;

   logic                    clk;
   logic                    rst;
   logic                    rdy;
   logic [RN-1:0]           req_valid;
   logic [RN-1:0][4:0]      req_warp;
   logic [RN-1:0][4:0]      req_reg;
   logic [RN-1:0]           req_ready;
   logic                    wb_valid;
   logic [4:0]              wb_warp;
   logic [4:0]              wb_reg;
   logic                    wb_ready;
   logic [BN-1:0]           bank_rd_en;
   logic [BN-1:0]           bank_write;
   logic [BN-1:0][2:0]      bank_reg_num;
   logic [BN-1:0][4:0]      bank_warp_num;
   logic [BN-1:0][DW-1:0]   bank_rdata;
   logic [RN-1:0]           resp_valid;
   logic [RN-1:0][DW-1:0]   resp_data;

   int n_vec = 0;
   int n_err = 0;
   int cyc_n = 0;

   gelato_register_bank_scheduler #(
      .BANK_NUM(BN), .REQ_NUM(RN), .WARP_W(5), .REG_W(5), .DATA_W(DW), .WB_STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .req_valid(req_valid), .req_warp(req_warp), .req_reg(req_reg), .req_ready(req_ready),
      .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_reg(wb_reg), .wb_ready(wb_ready),
      .bank_rd_en(bank_rd_en), .bank_write(bank_write),
      .bank_reg_num(bank_reg_num), .bank_warp_num(bank_warp_num),
      .bank_rdata(bank_rdata), .resp_valid(resp_valid), .resp_data(resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got(low64)=%h want(low64)=%h", nm, $time, act[63:0], exp[63:0]);
      end
   endtask

   // Bank b presents a replicated 32-bit word that changes every cycle.
   function automatic logic [DW-1:0] word(input int b);
      logic [31:0] w;
      w = 32'(cyc_n * 16 + b);
      return {(DW/32){w}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc_n++;
      for (int b = 0; b < BN; b++) bank_rdata[b] = word(b);
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   int          m_rr[BN];
   int          m_starve[BN];
   logic [RN-1:0] m_pend;
   int          m_pbank[RN];

   always @(negedge clk) begin : compare
      logic [RN-1:0]      e_ready;
      logic               e_wb;
      logic [BN-1:0]      e_rd, e_wr;
      logic [BN-1:0][2:0] e_row;
      logic [BN-1:0][4:0] e_warp;
      int                 q[$];
      int                 winner;
      logic               wbh;
      e_ready = '0; e_wb = 1'b0; e_rd = '0; e_wr = '0; e_row = '0; e_warp = '0;
      if (rst) begin
         for (int b = 0; b < BN; b++) begin m_rr[b] = 0; m_starve[b] = 0; end
         m_pend = '0;
         chk("rst_req_ready", 64'(req_ready), 64'(0));
         chk("rst_wb_ready", 64'(wb_ready), 64'(0));
         chk("rst_rd_en", 64'(bank_rd_en), 64'(0));
         chk("rst_write", 64'(bank_write), 64'(0));
         chk("rst_reg_num", 64'(bank_reg_num), 64'(0));
         chk("rst_warp_num", 64'(bank_warp_num), 64'(0));
         chk("rst_resp_valid", 64'(resp_valid), 64'(0));
         for (int i = 0; i < RN; i++) chk_data("rst_resp_data", resp_data[i], '0);
      end else begin
         for (int b = 0; b < BN; b++) begin
            q.delete();
            for (int i = 0; i < RN; i++)
               if (req_valid[i] && (int'(req_reg[i]) % BN == b)) q.push_back(i);
            wbh = wb_valid && (int'(wb_reg) % BN == b);
            winner = -1;
            foreach (q[k]) if (winner < 0 && q[k] >= m_rr[b]) winner = q[k];
            if (winner < 0 && q.size() > 0) winner = q[0];
            if (rdy) begin
               if (wbh && (q.size() == 0 || m_starve[b] < SMAX)) begin
                  e_wb = 1'b1; e_wr[b] = 1'b1;
                  e_row[b] = 3'(int'(wb_reg) / BN); e_warp[b] = wb_warp;
                  m_starve[b] = (q.size() > 0) ? m_starve[b] + 1 : 0;
               end else if (q.size() > 0) begin
                  e_rd[b] = 1'b1; e_ready[winner] = 1'b1;
                  e_row[b] = 3'(int'(req_reg[winner]) / BN); e_warp[b] = req_warp[winner];
                  m_rr[b] = (winner + 1) % RN;
                  m_starve[b] = 0;
               end else begin
                  m_starve[b] = 0;
               end
            end
         end
         chk("req_ready", 64'(req_ready), 64'(e_ready));
         chk("wb_ready", 64'(wb_ready), 64'(e_wb));
         chk("bank_rd_en", 64'(bank_rd_en), 64'(e_rd));
         chk("bank_write", 64'(bank_write), 64'(e_wr));
         chk("bank_reg_num", 64'(bank_reg_num), 64'(e_row));
         chk("bank_warp_num", 64'(bank_warp_num), 64'(e_warp));
         chk("resp_valid", 64'(resp_valid), 64'(m_pend));
         for (int i = 0; i < RN; i++)
            chk_data("resp_data", resp_data[i], m_pend[i] ? bank_rdata[m_pbank[i]] : '0);
         m_pend = e_ready;
         for (int i = 0; i < RN; i++) if (e_ready[i]) m_pbank[i] = int'(req_reg[i]) % BN;
      end
   end

   // ---------------- directed stimulus with hand expectations ----------------
   initial begin : stim
      static logic [4:0] wb_exp = 5'b10111;   // cycle k -> wb_ready (LSB = cycle 0)
      static logic [4:0] r1_exp = 5'b01000;   // cycle k -> req_ready[1]
      rst = 1'b1; rdy = 1'b1; req_valid = '0; wb_valid = 1'b0; wb_warp = 5'd7; wb_reg = '0;
      for (int i = 0; i < RN; i++) begin req_warp[i] = 5'(10 + i); req_reg[i] = '0; end
      for (int b = 0; b < BN; b++) bank_rdata[b] = word(b);
      tick(); tick();
      rst = 1'b0;

      // Conflict on bank 0: req0 reg4 vs req2 reg8
      req_reg[0] = 5'd4; req_reg[2] = 5'd8; req_valid = 4'b0101;
      #1 chk("conf_c0_ready", 64'(req_ready), 64'(4'b0001));
      tick(); req_valid = 4'b0100;
      #1 chk("conf_c1_ready", 64'(req_ready), 64'(4'b0100));
      chk("conf_c1_resp_valid0", 64'(resp_valid[0]), 64'(1));
      chk_data("conf_c1_resp_data0", resp_data[0], word(0));
      tick(); req_valid = 4'b0000;
      #1 chk("conf_c2_resp_valid", 64'(resp_valid), 64'(4'b0100));
      chk_data("conf_c2_resp_data2", resp_data[2], word(0));

      // Parallel: one request per bank, all row 0
      tick();
      for (int i = 0; i < RN; i++) req_reg[i] = 5'(i);
      req_valid = 4'b1111;
      #1 chk("par_ready", 64'(req_ready), 64'(4'b1111));
      chk("par_rd_en", 64'(bank_rd_en), 64'(4'b1111));
      chk("par_reg_num", 64'(bank_reg_num), 64'(0));
      tick(); req_valid = 4'b0000;
      #1 chk("par_resp_valid", 64'(resp_valid), 64'(4'b1111));
      chk_data("par_resp_data3", resp_data[3], word(3));

      // Starvation: writeback on reg5 (bank 1) against req1 reg1
      req_reg[1] = 5'd1; wb_reg = 5'd5; wb_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         req_valid = (k < 4) ? 4'b0010 : 4'b0000;
         #1 chk("starve_wb_ready", 64'(wb_ready), 64'(wb_exp[k]));
         chk("starve_req1", 64'(req_ready[1]), 64'(r1_exp[k]));
         tick();
      end
      wb_valid = 1'b0; req_valid = '0;

      // Writeback and read on different banks in the same cycle
      wb_valid = 1'b1; wb_reg = 5'd2; req_reg[3] = 5'd7; req_valid = 4'b1000;
      #1 chk("diff_write", 64'(bank_write), 64'(4'b0100));
      chk("diff_rd_en", 64'(bank_rd_en), 64'(4'b1000));
      chk("diff_warp_num", 64'(bank_warp_num), 64'({5'd13, 5'd7, 5'd0, 5'd0}));
      tick(); wb_valid = 1'b0; req_valid = '0;

      // rdy drop right after a grant
      req_reg[2] = 5'd8; req_valid = 4'b0100;
      #1 chk("rdy_grant", 64'(req_ready), 64'(4'b0100));
      tick(); rdy = 1'b0; req_reg[0] = 5'd4; req_valid = 4'b0101;
      #1 chk("rdy_low_ready", 64'(req_ready), 64'(0));
      chk("rdy_low_rd_en", 64'(bank_rd_en), 64'(0));
      chk("rdy_low_resp", 64'(resp_valid), 64'(4'b0100));
      chk_data("rdy_low_data", resp_data[2], word(0));
      tick();
      #1 chk("rdy_low_resp2", 64'(resp_valid), 64'(0));
      tick(); rdy = 1'b1;
      #1 chk("rdy_back_ready", 64'(req_ready), 64'(4'b0001));

      // Reset mid-traffic: four-way conflict on bank 0
      tick();
      req_reg[0] = 5'd0; req_reg[1] = 5'd4; req_reg[2] = 5'd8; req_reg[3] = 5'd12;
      req_valid = 4'b1111;
      #1 chk("pre_rst_ready", 64'(req_ready), 64'(4'b0010));
      tick();
      #1 chk("pre_rst_resp", 64'(resp_valid), 64'(4'b0010));
      #1 rst = 1'b1;
      #1 chk("rst_now_ready", 64'(req_ready), 64'(0));
      chk("rst_now_resp", 64'(resp_valid), 64'(0));
      chk_data("rst_now_data", resp_data[1], '0);
      tick(); tick(); rst = 1'b0;
      #1 chk("post_rst_ready", 64'(req_ready), 64'(4'b0001));
      tick(); req_valid = '0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
